// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction-memory loader.
// Consumes a byte stream of the form {N[15:8], N[7:0], 4*N data bytes, xor checksum},
// writes each data byte to BASE_ADDR+k with one cycle of latency, and holds the
// core in reset-like hold until a session completes with a matching checksum.
module imem_loader #(
    parameter int MEM_BYTES = 64,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wd,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    // Space available above the load base; a word count that needs more is rejected.
    localparam logic [31:0] CAP    = 32'(MEM_BYTES - BASE_ADDR);
    localparam logic [31:0] BASE_W = 32'(BASE_ADDR);

    state_t      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [17:0] cnt_q, cnt_d;
    logic [7:0]  csum_q, csum_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_wd_q, mem_wd_d;
    logic        in_ready_q, in_ready_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        cpu_hold_q, cpu_hold_d;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        logic        xfer;
        logic [31:0] n_bytes;
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_wd_d   = mem_wd_q;
        xfer       = in_valid && in_ready_q;
        n_bytes    = {14'b0, len_q[15:8], in_data, 2'b00};

        case (state_q)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_d = LEN_HI;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    if (n_bytes > CAP) begin
                        state_d = ERR;
                    end else if (n_bytes == '0) begin
                        state_d = CSUM;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    mem_we_d   = 1'b1;
                    mem_addr_d = BASE_W + {14'b0, cnt_q};
                    mem_wd_d   = in_data;
                    csum_d     = csum_q ^ in_data;
                    cnt_d      = cnt_q + 18'd1;
                    if (cnt_q + 18'd1 == {len_q, 2'b00}) begin
                        state_d = CSUM;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d = (in_data == csum_q) ? DONE : ERR;
                end
            end
            default: state_d = IDLE;
        endcase

        // Status outputs are registered by decoding the next state.
        in_ready_d = (state_d == LEN_HI) || (state_d == LEN_LO) ||
                     (state_d == DATA)   || (state_d == CSUM);
        busy_d     = in_ready_d;
        done_d     = (state_d == DONE);
        err_d      = (state_d == ERR);
        cpu_hold_d = (state_d != DONE);
    end

    // State and output registers; async reset also drops any pending write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_wd_q   <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_hold_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wd_q   <= mem_wd_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_hold_q <= cpu_hold_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_wd   = mem_wd_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign cpu_hold = cpu_hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: basic load, bad checksum, overflow, empty load,
// backpressure with an ignored start, and reset in the middle of a load.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wd;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [31:0] wr_addr[$];
    logic [7:0]  wr_data[$];
    logic [7:0]  exp_d[4] = '{8'h20, 8'h01, 8'hAB, 8'hE6};

    imem_loader #(.MEM_BYTES(64), .BASE_ADDR(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Capture memory writes mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wd);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Present one byte after `gap` idle cycles and hold it until it is accepted.
    task automatic send(input logic [7:0] b, input int unsigned gap);
        int unsigned guard;
        in_valid = 1'b0;
        tick(gap);
        in_valid = 1'b1;
        in_data  = b;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            tick(1);
            guard++;
        end
        if (guard >= 50) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tick(1);
        in_valid = 1'b0;
    endtask

    task automatic clear_writes();
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic check_basic_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr.size()), 32'd4);
        if (wr_addr.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s_addr%0d", tag, i), wr_addr[i], 32'(i));
                check($sformatf("%s_data%0d", tag, i), 32'(wr_data[i]), 32'(exp_d[i]));
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_mem_we"},   32'(mem_we),   32'd0);
        check({tag, "_mem_addr"}, mem_addr,      32'd0);
        check({tag, "_mem_wd"},   32'(mem_wd),   32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    endtask

    // Full basic session with optional random gaps and a mid-DATA start pulse.
    task automatic basic_session(input string tag, input int unsigned gmax, input bit mid_start);
        clear_writes();
        pulse_start();
        check({tag, "_busy"}, 32'(busy), 32'd1);
        send(8'h00, $urandom_range(0, gmax));
        send(8'h01, $urandom_range(0, gmax));
        send(8'h20, $urandom_range(0, gmax));
        send(8'h01, $urandom_range(0, gmax));
        if (mid_start) begin
            start = 1'b1;
            tick(1);
            start = 1'b0;
            check({tag, "_ign_busy"}, 32'(busy), 32'd1);
            check({tag, "_ign_rdy"},  32'(in_ready), 32'd1);
        end
        send(8'hAB, $urandom_range(0, gmax));
        send(8'hE6, $urandom_range(0, gmax));
        send(8'h6C, $urandom_range(0, gmax));
        tick(2);
        check_basic_writes(tag);
        check({tag, "_done"},     32'(done),     32'd1);
        check({tag, "_err"},      32'(err),      32'd0);
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_busy_end"}, 32'(busy),     32'd0);
    endtask

    initial begin
        tick(3);
        check_reset_outputs("rst");
        reset = 1'b0;
        tick(2);
        check("idle_wait_busy", 32'(busy), 32'd0);

        // Basic load with latency/hold checks on the first data byte.
        clear_writes();
        pulse_start();
        check("b_rdy", 32'(in_ready), 32'd1);
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'h20, 0);
        check("lat_we",   32'(mem_we),   32'd1);
        check("lat_addr", mem_addr,      32'd0);
        check("lat_wd",   32'(mem_wd),   32'h20);
        tick(1);
        check("hold_we",   32'(mem_we),  32'd0);
        check("hold_addr", mem_addr,     32'd0);
        check("hold_wd",   32'(mem_wd),  32'h20);
        check("stall_busy", 32'(busy),   32'd1);
        send(8'h01, 0);
        send(8'hAB, 0);
        send(8'hE6, 0);
        check("pre_csum_done", 32'(done), 32'd0);
        send(8'h6C, 0);
        tick(2);
        check_basic_writes("basic");
        check("basic_done", 32'(done), 32'd1);
        check("basic_hold", 32'(cpu_hold), 32'd0);
        tick(3);
        check("basic_sticky", 32'(done), 32'd1);

        // Bad checksum.
        clear_writes();
        pulse_start();
        check("bad_done_clr", 32'(done), 32'd0);
        send(8'h00, 0); send(8'h01, 0); send(8'h20, 0);
        send(8'h01, 0); send(8'hAB, 0); send(8'hE6, 0); send(8'h6D, 0);
        tick(2);
        check_basic_writes("bad");
        check("bad_err",  32'(err),      32'd1);
        check("bad_done", 32'(done),     32'd0);
        check("bad_hold", 32'(cpu_hold), 32'd1);

        // Overflow: 17 words > 64 bytes.
        clear_writes();
        pulse_start();
        send(8'h00, 0);
        send(8'h11, 0);
        check("ovf_err", 32'(err),      32'd1);
        check("ovf_rdy", 32'(in_ready), 32'd0);
        tick(3);
        check("ovf_nwr", 32'(wr_addr.size()), 32'd0);
        check("ovf_sticky", 32'(err), 32'd1);

        // Empty load.
        clear_writes();
        pulse_start();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        tick(2);
        check("empty_nwr",  32'(wr_addr.size()), 32'd0);
        check("empty_done", 32'(done), 32'd1);
        check("empty_err",  32'(err),  32'd0);

        // Backpressure plus ignored start.
        basic_session("bp", 3, 1'b1);

        // Reset mid-DATA right after the second data byte is accepted.
        clear_writes();
        pulse_start();
        send(8'h00, 0); send(8'h01, 0); send(8'h20, 0); send(8'h01, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        tick(2);
        check("mid_rst_nwr", 32'(wr_addr.size()), 32'd1);
        check("mid_rst_we",  32'(mem_we), 32'd0);
        reset = 1'b0;
        tick(3);
        check("post_rst_busy", 32'(busy), 32'd0);
        basic_session("after_rst", 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
